// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - rx_state_t : receiver FSM state encoding
//   - DATA_BITS  : payload bits per frame (8N1)
//   - calc_div   : clock cycles per oversample tick, integer-truncated
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Truncating division: the tick period never exceeds the ideal value, so
  // the sampling point drifts slightly early instead of late.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through synchronous FIFO for received bytes.
//   clk50   in   clock
//   reset   in   synchronous active-high reset; discards contents
//   wr_en   in   push request (dropped when full with no simultaneous pop)
//   wr_data in   byte to push
//   rd_en   in   pop the head byte; ignored when empty
//   rd_data out  head byte, registered; 0 while empty
//   empty   out  no bytes stored
//   full    out  DEPTH bytes stored
//   count   out  bytes stored
//   drop    out  push rejected this cycle because the FIFO is full
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW-1:0]        rd_ptr_next;
  logic [AW:0]          count_reg;
  logic [AW:0]          count_next;
  logic [DATA_BITS-1:0] rd_data_reg;
  logic                 push;
  logic                 pop;
  logic                 head_bypass;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push that coincides with a pop.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    count_next  = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    // The byte being written this cycle becomes the new head when it lands
    // at the address the head register will read next.
    head_bypass = push && (wr_ptr_reg == rd_ptr_next);
  end

  always_ff @(posedge clk50) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // rd_data is a registered read of the next head, so a push into an empty
  // FIFO is visible on the cycle after the push together with empty=0.
  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next == '0) begin
        rd_data_reg <= '0;
      end else if (head_bypass) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a FWFT FIFO.
//   clk50     in   UART clock, the only clock
//   reset     in   synchronous active-high reset; aborts a frame, empties FIFO
//   rx        in   asynchronous serial line, idles high
//   rd_en     in   pop the head byte; ignored when empty
//   rd_data   out  head byte, valid while empty=0
//   empty     out  FIFO holds no bytes
//   full      out  FIFO holds FIFO_DEPTH bytes
//   count     out  bytes stored
//   frame_err out  1-cycle pulse when a stop bit is sampled low
//   overrun   out  1-cycle pulse when a byte is dropped on a full FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Sample-count landmarks: mid start bit and the last sample of a bit.
  localparam logic [3:0] SC_MID  = 4'd7;
  localparam logic [3:0] SC_LAST = 4'd15;

  logic                 rx_meta_reg;
  logic                 rx_sync_reg;
  logic [DIV_W-1:0]     div_reg;
  logic                 tick;

  rx_state_t            state_reg, state_next;
  logic [3:0]           sc_reg, sc_next;
  logic [2:0]           bc_reg, bc_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg;
  logic                 push;
  logic                 drop;

  // Two-flop synchroniser; both stages reset to the idle line level so a
  // reset never looks like a start bit.
  always_ff @(posedge clk50) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Tick divider is held clear in IDLE so tick phase is locked to the
  // detected start edge.
  assign tick = (div_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk50) begin
    if (reset || state_reg == IDLE) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sc_next        = sc_reg;
    bc_next        = bc_reg;
    shreg_next     = shreg_reg;
    push           = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_sync_reg) begin
          state_next = START;
          sc_next    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sc_reg == SC_MID) begin
            // Still low at mid start bit: a real frame; otherwise a glitch.
            state_next = rx_sync_reg ? IDLE : DATA;
            sc_next    = '0;
            bc_next    = '0;
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc_reg == SC_LAST) begin
            shreg_next = {rx_sync_reg, shreg_reg[DATA_BITS-1:1]};
            bc_next    = bc_reg + 1'b1;
            sc_next    = '0;
            if (bc_reg == 3'd7) begin
              state_next = STOP;
            end
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sc_reg == SC_LAST) begin
            if (rx_sync_reg) begin
              push       = 1'b1;
              state_next = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = BREAK;
            end
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a long low level cannot
        // be mistaken for a stream of start bits.
        if (rx_sync_reg) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_reg     <= IDLE;
      sc_reg        <= '0;
      bc_reg        <= '0;
      shreg_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sc_reg        <= sc_next;
      bc_reg        <= bc_next;
      shreg_reg     <= shreg_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= drop;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk50   (clk50),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (shreg_reg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .drop    (drop)
  );

  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Runs at a reduced clock (DIV=5 after truncation,
// 80 clocks per bit) so the full scenario list stays short. Expected bytes
// are queued when a frame is issued; a negedge monitor pops and compares
// every byte the DUT hands out.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 9_500_000;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int DIVM   = CLK_HZ / (BAUD * OS);
  localparam int BITC   = DIVM * OS;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic          rx    = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial forever #5 clk50 = ~clk50;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         exp_fe = 0;
  int         exp_ov = 0;
  int         seen_fe = 0;
  int         seen_ov = 0;
  int         last_fall = -1;
  int         start_cyc = 0;
  logic       prev_empty = 1'b1;

  initial forever begin
    @(posedge clk50);
    cyc++;
  end

  // Monitor: pulse counters, empty-fall timestamp, and the pop scoreboard.
  initial forever begin
    logic [7:0] e;
    @(negedge clk50);
    if (frame_err === 1'b1) seen_fe++;
    if (overrun === 1'b1) seen_ov++;
    if (prev_empty === 1'b1 && empty === 1'b0) last_fall = cyc;
    prev_empty = empty;
    if (rd_en === 1'b1 && empty === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop: got 0x%02h, required nothing (scoreboard empty)", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL pop: got 0x%02h, required 0x%02h", rd_data, e);
        end else begin
          $display("pop   byte 0x%02h ok", rd_data);
        end
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Drive one 8N1 frame. stop_low>0 holds the stop bit low for that many bit
  // times; pop_at>=0 pulses rd_en at that cycle offset; rst_at>=0 pulses
  // reset at that offset and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input int stop_low,
                            input int pop_at, input int rst_at);
    int total;
    int b;
    total = (stop_low > 0) ? (9 + stop_low) * BITC : 10 * BITC;
    if (rst_at < 0) begin
      if (stop_low > 0) exp_fe++;
      else if (exp_q.size() < DEPTH || pop_at >= 0) exp_q.push_back(data);
      else exp_ov++;
    end
    $display("frame 0x%02h stop_low=%0d pop_at=%0d rst_at=%0d", data, stop_low, pop_at, rst_at);
    start_cyc = cyc;
    for (int c = 0; c < total; c++) begin
      b = c / BITC;
      if (c == rst_at) begin
        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (b == 0) rx = 1'b0;
      else if (b <= 8) rx = data[b-1];
      else rx = (stop_low > 0) ? 1'b0 : 1'b1;
      if (pop_at >= 0) rd_en = (c == pop_at);
      step();
    end
    rx = 1'b1;
    if (pop_at >= 0) rd_en = 1'b0;
    wait_cycles(BITC);
  endtask

  task automatic drain(input string name);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step();
      if (empty === 1'b1) break;
    end
    rd_en = 1'b0;
    step();
    check({name, " leftover expected"}, exp_q.size(), 0);
    check({name, " empty"}, int'(empty), 1);
  endtask

  initial begin
    int lat;
    int pop_at;
    logic [7:0] d;
    int bad;

    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    step();
    check("reset empty", int'(empty), 1);
    check("reset full", int'(full), 0);
    check("reset count", int'(count), 0);
    check("reset rd_data", int'(rd_data), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);

    // 1: single clean frame, latency ~9.5 bit times plus a few clocks
    last_fall = -1;
    send_frame(8'h55, 0, -1, -1);
    lat = last_fall - start_cyc;
    check_range("t1 latency", lat, (19 * BITC) / 2, (19 * BITC) / 2 + 16);
    check("t1 rd_data", int'(rd_data), 'h55);
    check("t1 frame_err", seen_fe, exp_fe);
    drain("t1");
    pop_at = (lat > 0 && lat < 10 * BITC) ? lat - 1 : (19 * BITC) / 2 + 2;

    // 2: short low glitch is rejected, next frame is fine
    rx = 1'b0;
    wait_cycles(BITC / 4);
    rx = 1'b1;
    wait_cycles(2 * BITC);
    check("t2 glitch count", int'(count), 0);
    check("t2 glitch frame_err", seen_fe, exp_fe);
    send_frame(8'hE1, 0, -1, -1);
    check("t2 count", int'(count), 1);
    drain("t2");

    // 3: stop bit held low -> one frame_err, nothing stored
    send_frame(8'hA3, 2, -1, -1);
    check("t3 frame_err", seen_fe, exp_fe);
    check("t3 count", int'(count), 0);
    send_frame(8'h3C, 0, -1, -1);
    check("t3 rd_data", int'(rd_data), 'h3C);
    drain("t3");

    // 4: fill to full, one overrun on the 17th byte
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 0, -1, -1);
      if (i == 15) begin
        check("t4 full", int'(full), 1);
        check("t4 count", int'(count), DEPTH);
      end
    end
    check("t4 overrun", seen_ov, exp_ov);
    check("t4 count after drop", int'(count), DEPTH);

    // 5: pop in the exact push cycle while full
    send_frame(8'h11, 0, pop_at, -1);
    check("t5 count", int'(count), DEPTH);
    check("t5 overrun", seen_ov, exp_ov);
    drain("t5");

    // 6: reset mid-frame discards FIFO and frame
    send_frame(8'($urandom_range(255)), 0, -1, -1);
    send_frame(8'($urandom_range(255)), 0, -1, -1);
    send_frame(8'h5A, 0, -1, 4 * BITC + 7);
    check("t6 empty", int'(empty), 1);
    check("t6 count", int'(count), 0);
    check("t6 rd_data", int'(rd_data), 0);
    wait_cycles(2 * BITC);
    send_frame(8'hC7, 0, -1, -1);
    check("t6 rd_data", int'(rd_data), 'hC7);
    drain("t6");

    // random frames, some with a bad stop bit
    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom_range(255));
      bad = ($urandom_range(4) == 0) ? 1 : 0;
      send_frame(d, bad, -1, -1);
      wait_cycles($urandom_range(0, BITC));
      check("rand count", int'(count), exp_q.size());
      check("rand frame_err", seen_fe, exp_fe);
    end
    drain("rand");
    check("final overrun", seen_ov, exp_ov);
    check("final frame_err", seen_fe, exp_fe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
